pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage datapath. Watches the EX/MEM pipeline register outputs and the ID/EX and IF/ID hazard fields, and drives the stall and flush enables of PC, IF/ID and ID/EX. Sequences variable-latency data-memory accesses through a req/ack handshake, resolves BEQ/BNE branches, inserts load-use bubbles and counts stall cycles. Sits beside the pipeline registers; owns no datapath state beyond the latched memory request.

Parameters:
DATA_W, 32, width of ALU result / write data / memory address and data
BR_W, 7, width of branch target address
REG_W, 5, register index width
MEM_TIMEOUT, 64, MEM_WAIT cycles without ack before HALTED (>=2)
CNT_W, 16, stall counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
memRead  in  1  EX/MEM load flag
memWrite  in  1  EX/MEM store flag
branch  in  1  EX/MEM branch flag
ZF  in  1  EX/MEM zero flag
BNE  in  1  EX/MEM branch-if-not-equal flag
branchAddress  in  BR_W  EX/MEM branch target
aluResult  in  DATA_W  EX/MEM address
writeData  in  DATA_W  EX/MEM store data
idExMemRead  in  1  ID/EX load flag
idExRd  in  REG_W  ID/EX destination
ifIdRs  in  REG_W  IF/ID source 1
ifIdRt  in  REG_W  IF/ID source 2
memAck  in  1  data memory completion, one-cycle pulse
pcWrite  out  1  PC enable
ifIdWrite  out  1  IF/ID enable
ifIdFlush  out  1  zero IF/ID on next edge
idExFlush  out  1  zero ID/EX control (bubble)
exMemHold  out  1  EX/MEM hold (no update)
pcSrc  out  1  select branch target
branchTarget  out  BR_W  target to PC mux
memReq  out  1  registered memory request
memWe  out  1  registered write enable
memAddr  out  DATA_W  registered address
memWdata  out  DATA_W  registered store data
memError  out  1  sticky timeout flag
stallCount  out  CNT_W  saturating count of memory-stall cycles

Behaviour:
- Reset (async): state RUN; memReq, memWe, memError 0; memAddr, memWdata, stallCount 0; wait counter 0.
- memOp = memRead | memWrite. taken = branch & (ZF ^ BNE).
- States: RUN, MEM_WAIT, HALTED.
- memStall (combinational) = (RUN & memOp) | (MEM_WAIT & !memAck) | HALTED.
- RUN & memOp: next state MEM_WAIT; latch memAddr=aluResult, memWdata=writeData, memWe=memWrite; memReq<=1; wait counter cleared.
- MEM_WAIT: memReq held 1, counter increments. memAck=1 -> memReq<=0, state RUN, stall released this cycle so pipeline advances at this edge. Counter reaching MEM_TIMEOUT-1 without ack -> memReq<=0, memError<=1, state HALTED.
- HALTED: stall forever; leave only on reset. memAck ignored outside MEM_WAIT.
- memStall=1: pcWrite=0, ifIdWrite=0, exMemHold=1, idExFlush=0, ifIdFlush=0, pcSrc=0.
- Branch (memStall=0, taken=1): pcSrc=1, branchTarget=branchAddress, ifIdFlush=1, idExFlush=1; pcWrite=1. Branch with memOp set cannot occur by decode; if it does, memory is serviced first and branch resolved in the ack cycle.
- Load-use (memStall=0, taken=0): idExMemRead & idExRd!=0 & (idExRd==ifIdRs | idExRd==ifIdRt) -> pcWrite=0, ifIdWrite=0, idExFlush=1. Exactly one bubble per hazard.
- Priority: reset > memStall > branch > load-use. Default: pcWrite=1, ifIdWrite=1, all flush/hold 0, pcSrc=0.
- branchTarget always mirrors branchAddress.
- stallCount increments each cycle memStall=1, saturates at all-ones.
- Memory latency: issue cycle (stall) + N wait cycles; ack as early as first MEM_WAIT cycle gives 1 stall cycle total.

Decomposition:
- Shared package: state encoding (RUN=0, MEM_WAIT=1, HALTED=2), BR_W/REG_W/DATA_W defaults, load-use and taken helper functions.
- One sub-module: mem_req_fsm (state, wait counter, latched request, memError); hazard/branch logic stays combinational in top.

Test Plan:
- Reset mid-MEM_WAIT with memReq=1 -> memReq, state, stallCount 0 asynchronously; RUN next cycle.
- memRead=1, aluResult=0x100, ack after 3 wait cycles -> memAddr=0x100, memWe=0, memReq high 3 cycles + ack cycle, stallCount=4, pcWrite low 4 cycles.
- branch=1, ZF=1, BNE=0, branchAddress=0x2A -> pcSrc=1, branchTarget=0x2A, ifIdFlush=idExFlush=1 that cycle; BNE=1 same ZF -> no flush.
- idExMemRead=1, idExRd=5, ifIdRt=5 -> one cycle pcWrite=0, ifIdWrite=0, idExFlush=1; idExRd=0 -> no stall.
- memWrite=1, no ack for MEM_TIMEOUT cycles -> memError=1, HALTED, pcWrite stays 0; later memAck ignored.
- Load-use and memOp together -> only memory stall outputs (idExFlush=0); stallCount saturates at 0xFFFF under forced stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int BR_W_DEF        = 7;
  localparam int REG_W_DEF       = 5;
  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 64;

  // Memory sequencer states; encoding is visible on debug taps, keep it fixed.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } mem_state_e;

  // BEQ takes on zero, BNE takes on non-zero.
  function automatic logic branch_taken(input logic branch, input logic zf, input logic bne);
    return branch & (zf ^ bne);
  endfunction

  // A load in ID/EX feeding either IF/ID source; r0 never creates a hazard.
  function automatic logic load_use(input logic id_ex_mem_read, input logic rd_nonzero,
                                    input logic rs_match, input logic rt_match);
    return id_ex_mem_read & rd_nonzero & (rs_match | rt_match);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-register taps, memory handshake and pipeline enables.
// Latency: n/a (wires only).
// Backpressure: memAck completes the registered memReq; no other flow control.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BR_W   = BR_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  // EX/MEM taps
  logic              memRead;
  logic              memWrite;
  logic              branch;
  logic              ZF;
  logic              BNE;
  logic [BR_W-1:0]   branchAddress;
  logic [DATA_W-1:0] aluResult;
  logic [DATA_W-1:0] writeData;
  // ID/EX and IF/ID hazard fields
  logic              idExMemRead;
  logic [REG_W-1:0]  idExRd;
  logic [REG_W-1:0]  ifIdRs;
  logic [REG_W-1:0]  ifIdRt;
  // data memory completion
  logic              memAck;
  // pipeline control
  logic              pcWrite;
  logic              ifIdWrite;
  logic              ifIdFlush;
  logic              idExFlush;
  logic              exMemHold;
  logic              pcSrc;
  logic [BR_W-1:0]   branchTarget;
  // data memory request
  logic              memReq;
  logic              memWe;
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  // status
  logic              memError;
  logic [CNT_W-1:0]  stallCount;

  // Pipeline/memory side
  modport master (
    output memRead, memWrite, branch, ZF, BNE, branchAddress, aluResult, writeData,
           idExMemRead, idExRd, ifIdRs, ifIdRt, memAck,
    input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemHold, pcSrc, branchTarget,
           memReq, memWe, memAddr, memWdata, memError, stallCount
  );

  // Controller side
  modport slave (
    input  memRead, memWrite, branch, ZF, BNE, branchAddress, aluResult, writeData,
           idExMemRead, idExRd, ifIdRs, ifIdRt, memAck,
    output pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemHold, pcSrc, branchTarget,
           memReq, memWe, memAddr, memWdata, memError, stallCount
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_mem_req_fsm.sv
// Sequences one data-memory access at a time and latches its address/data.
// Latency: request registered the edge after issue; release in the ack cycle.
// Backpressure: mem_stall holds the pipeline until ack; timeout halts forever.
module pipeline_hazard_ctrl_mem_req_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_op,
  input  logic              mem_write,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_error
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              error_q, error_d;

  // Next-state: issue from RUN, wait for ack or time out, park in HALTED.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;
    case (state_q)
      ST_RUN: begin
        if (mem_op) begin
          state_d    = ST_MEM_WAIT;
          req_d      = 1'b1;
          we_d       = mem_write;
          addr_d     = alu_result;
          wdata_d    = write_data;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        // Ack wins over timeout when both land in the last wait cycle.
        if (mem_ack) begin
          state_d = ST_RUN;
          req_d   = 1'b0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_HALTED;
          req_d   = 1'b0;
          error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        // Unreachable encoding: fail safe by stopping the pipeline.
        state_d = ST_HALTED;
        req_d   = 1'b0;
        error_d = 1'b1;
      end
    endcase
  end

  // Sequencer state and latched request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
    end
  end

  // Stall in the issue cycle and every wait cycle up to (not including) the ack.
  assign mem_stall = ((state_q == ST_RUN) & mem_op)
                   | ((state_q == ST_MEM_WAIT) & ~mem_ack)
                   | (state_q == ST_HALTED);

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_error = error_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Drives PC/IF/ID/ID/EX enables from memory stalls, taken branches and load-use.
// Latency: enables are combinational; memory request registered one edge later.
// Backpressure: memory stall freezes PC, IF/ID and EX/MEM until memAck.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BR_W        = BR_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  pipeline_hazard_ctrl_if.slave bus
);

  logic              mem_stall;
  logic              taken;
  logic              hazard;
  logic [REG_W-1:0]  id_ex_rd;
  logic [BR_W-1:0]   branch_target;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, pc_src;

  pipeline_hazard_ctrl_mem_req_fsm #(
    .DATA_W      (DATA_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) mem_req_fsm (
    .clock      (clock),
    .reset      (reset),
    .mem_op     (bus.memRead | bus.memWrite),
    .mem_write  (bus.memWrite),
    .mem_ack    (bus.memAck),
    .alu_result (bus.aluResult),
    .write_data (bus.writeData),
    .mem_stall  (mem_stall),
    .mem_req    (bus.memReq),
    .mem_we     (bus.memWe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_error  (bus.memError)
  );

  assign id_ex_rd      = bus.idExRd;
  assign branch_target = bus.branchAddress;
  assign taken         = branch_taken(bus.branch, bus.ZF, bus.BNE);
  assign hazard        = load_use(bus.idExMemRead, id_ex_rd != '0,
                                  id_ex_rd == bus.ifIdRs, id_ex_rd == bus.ifIdRt);

  // Pipeline enables, priority memory stall > taken branch > load-use bubble.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_hold = 1'b0;
    pc_src      = 1'b0;
    if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_mem_hold = 1'b1;
    end else if (taken) begin
      pc_src      = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Saturating count of cycles lost to memory.
  always_comb begin
    stall_count_d = stall_count_q;
    if (mem_stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pcWrite      = pc_write;
  assign bus.ifIdWrite    = if_id_write;
  assign bus.ifIdFlush    = if_id_flush;
  assign bus.idExFlush    = id_ex_flush;
  assign bus.exMemHold    = ex_mem_hold;
  assign bus.pcSrc        = pc_src;
  assign bus.branchTarget = branch_target;
  assign bus.memAddr      = mem_addr;
  assign bus.memWdata     = mem_wdata;
  assign bus.stallCount   = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: behavioural model compared every cycle plus directed literals.
// Latency: n/a.
// Backpressure: memAck driven randomly or by directed sequences.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 64;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clock;
  logic reset;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .DATA_W(32), .BR_W(7), .REG_W(5), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy, m_halted, m_err, m_we;
  int          m_wait, m_stalls;
  logic [31:0] m_addr, m_wdata;

  function automatic bit exp_stall();
    bit op;
    op = bus.memRead | bus.memWrite;
    if (m_halted) return 1'b1;
    if (m_busy)   return !bus.memAck;
    return op;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_halted = 0; m_err = 0; m_we = 0;
      m_wait = 0; m_stalls = 0; m_addr = '0; m_wdata = '0;
    end else begin
      if (exp_stall() && m_stalls < CNT_MAX) m_stalls++;
      if (m_halted) begin
      end else if (m_busy) begin
        if (bus.memAck) m_busy = 0;
        else if (m_wait == MEM_TIMEOUT - 1) begin
          m_busy = 0; m_halted = 1; m_err = 1;
        end else m_wait++;
      end else if (bus.memRead || bus.memWrite) begin
        m_busy = 1; m_wait = 0;
        m_addr = bus.aluResult; m_wdata = bus.writeData; m_we = bus.memWrite;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (!reset) begin
      bit st, tk, lu;
      bit e_pcw, e_ifw, e_iff, e_idf, e_hold, e_src;
      st = exp_stall();
      tk = bus.branch && (bus.ZF != bus.BNE);
      lu = bus.idExMemRead && bus.idExRd != 0 &&
           (bus.idExRd == bus.ifIdRs || bus.idExRd == bus.ifIdRt);
      e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0; e_src = 0;
      if (st) begin
        e_pcw = 0; e_ifw = 0; e_hold = 1;
      end else if (tk) begin
        e_src = 1; e_iff = 1; e_idf = 1;
      end else if (lu) begin
        e_pcw = 0; e_ifw = 0; e_idf = 1;
      end
      chk("pcWrite",      32'(bus.pcWrite),      32'(e_pcw));
      chk("ifIdWrite",    32'(bus.ifIdWrite),    32'(e_ifw));
      chk("ifIdFlush",    32'(bus.ifIdFlush),    32'(e_iff));
      chk("idExFlush",    32'(bus.idExFlush),    32'(e_idf));
      chk("exMemHold",    32'(bus.exMemHold),    32'(e_hold));
      chk("pcSrc",        32'(bus.pcSrc),        32'(e_src));
      chk("branchTarget", 32'(bus.branchTarget), 32'(bus.branchAddress));
      chk("memReq",       32'(bus.memReq),       32'(m_busy));
      chk("memWe",        32'(bus.memWe),        32'(m_we));
      chk("memAddr",      bus.memAddr,           m_addr);
      chk("memWdata",     bus.memWdata,          m_wdata);
      chk("memError",     32'(bus.memError),     32'(m_err));
      chk("stallCount",   32'(bus.stallCount),   32'(m_stalls));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic at_neg();
    @(negedge clock); #1;
  endtask

  task automatic clear_inputs();
    bus.memRead = 0; bus.memWrite = 0; bus.branch = 0; bus.ZF = 0; bus.BNE = 0;
    bus.branchAddress = '0; bus.aluResult = '0; bus.writeData = '0;
    bus.idExMemRead = 0; bus.idExRd = '0; bus.ifIdRs = '0; bus.ifIdRt = '0;
    bus.memAck = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    int pw_low, rq_hi;
    reset = 1;
    clear_inputs();
    #12;
    chk("rst memReq",     32'(bus.memReq),     32'd0);
    chk("rst memError",   32'(bus.memError),   32'd0);
    chk("rst stallCount", 32'(bus.stallCount), 32'd0);
    chk("rst memAddr",    bus.memAddr,         32'd0);
    chk("rst pcWrite",    32'(bus.pcWrite),    32'd1);
    tick();
    reset = 0;

    // Load with ack after three wait cycles.
    bus.memRead = 1; bus.aluResult = 32'h100; bus.writeData = 32'hDEAD;
    pw_low = 0; rq_hi = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      bus.memAck = (cyc == 4);
      at_neg();
      if (!bus.pcWrite) pw_low++;
      if (bus.memReq) rq_hi++;
      if (cyc == 1) begin
        chk("ld memAddr", bus.memAddr, 32'h100);
        chk("ld memWe",   32'(bus.memWe), 32'd0);
      end
      tick();
    end
    bus.memRead = 0; bus.memAck = 0;
    chk("ld pcWrite low cycles", 32'(pw_low), 32'd4);
    chk("ld memReq high cycles", 32'(rq_hi),  32'd4);
    chk("ld stallCount",         32'(bus.stallCount), 32'd4);
    chk("ld memReq after ack",   32'(bus.memReq), 32'd0);

    // Taken BEQ, then same flags with BNE (not taken).
    bus.branch = 1; bus.ZF = 1; bus.BNE = 0; bus.branchAddress = 7'h2A;
    at_neg();
    chk("beq pcSrc",        32'(bus.pcSrc),        32'd1);
    chk("beq branchTarget", 32'(bus.branchTarget), 32'h2A);
    chk("beq ifIdFlush",    32'(bus.ifIdFlush),    32'd1);
    chk("beq idExFlush",    32'(bus.idExFlush),    32'd1);
    tick();
    bus.BNE = 1;
    at_neg();
    chk("bne pcSrc",     32'(bus.pcSrc),     32'd0);
    chk("bne ifIdFlush", 32'(bus.ifIdFlush), 32'd0);
    tick();
    bus.branch = 0; bus.ZF = 0; bus.BNE = 0;

    // Load-use on rt, then r0 destination.
    bus.idExMemRead = 1; bus.idExRd = 5; bus.ifIdRt = 5; bus.ifIdRs = 3;
    at_neg();
    chk("lu pcWrite",   32'(bus.pcWrite),   32'd0);
    chk("lu ifIdWrite", 32'(bus.ifIdWrite), 32'd0);
    chk("lu idExFlush", 32'(bus.idExFlush), 32'd1);
    tick();
    bus.idExRd = 0; bus.ifIdRt = 0;
    at_neg();
    chk("lu r0 pcWrite", 32'(bus.pcWrite), 32'd1);
    tick();

    // Load-use together with a memory op: memory stall only.
    bus.idExRd = 5; bus.ifIdRs = 5; bus.memRead = 1; bus.aluResult = 32'h44;
    at_neg();
    chk("lu+mem idExFlush", 32'(bus.idExFlush), 32'd0);
    chk("lu+mem exMemHold", 32'(bus.exMemHold), 32'd1);
    tick();
    bus.memAck = 1;
    tick();
    clear_inputs();
    tick();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.memRead       = ($urandom_range(0, 5) == 0);
      bus.memWrite      = ($urandom_range(0, 5) == 0);
      bus.branch        = ($urandom_range(0, 2) == 0);
      bus.ZF            = $urandom_range(0, 1);
      bus.BNE           = $urandom_range(0, 1);
      bus.branchAddress = 7'($urandom);
      bus.aluResult     = $urandom;
      bus.writeData     = $urandom;
      bus.idExMemRead   = $urandom_range(0, 1);
      bus.idExRd        = 5'($urandom_range(0, 7));
      bus.ifIdRs        = 5'($urandom_range(0, 7));
      bus.ifIdRt        = 5'($urandom_range(0, 7));
      bus.memAck        = ($urandom_range(0, 2) == 0);
      tick();
    end
    do_reset();

    // Asynchronous reset while a request is outstanding.
    bus.memRead = 1; bus.aluResult = 32'h55;
    tick();
    tick();
    chk("pre-rst memReq", 32'(bus.memReq), 32'd1);
    #2;
    reset = 1;
    #1;
    chk("async rst memReq",     32'(bus.memReq),     32'd0);
    chk("async rst stallCount", 32'(bus.stallCount), 32'd0);
    clear_inputs();
    tick();
    reset = 0;
    at_neg();
    chk("post-rst pcWrite", 32'(bus.pcWrite), 32'd1);
    tick();
    bus.memRead = 1;
    at_neg();
    chk("post-rst issue hold", 32'(bus.exMemHold), 32'd1);
    tick();
    bus.memAck = 1;
    tick();
    clear_inputs();
    do_reset();

    // Store never acked: timeout into HALTED, then saturate the stall counter.
    bus.memWrite = 1; bus.aluResult = 32'h200; bus.writeData = 32'hCAFE;
    repeat (MEM_TIMEOUT) tick();
    chk("last wait memError", 32'(bus.memError), 32'd0);
    chk("last wait memReq",   32'(bus.memReq),   32'd1);
    tick();
    chk("halt memError",   32'(bus.memError),   32'd1);
    chk("halt memReq",     32'(bus.memReq),     32'd0);
    chk("halt memWe",      32'(bus.memWe),      32'd1);
    chk("halt stallCount", 32'(bus.stallCount), 32'd65);
    bus.memWrite = 0; bus.memAck = 1;
    at_neg();
    chk("halt ack pcWrite", 32'(bus.pcWrite), 32'd0);
    tick();
    bus.memAck = 0;
    chk("halt ack memReq",   32'(bus.memReq),   32'd0);
    chk("halt ack memError", 32'(bus.memError), 32'd1);
    repeat (65600) tick();
    chk("sat stallCount", 32'(bus.stallCount), 32'hFFFF);
    at_neg();
    chk("sat pcWrite", 32'(bus.pcWrite), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
